// File: rtl/regression_controller.sv
// Sequencer for the two-pass linear-regression datapath: streams the sample memory twice
// (means, then cross/square sums) and finishes by loading the slope, then the intercept.
module regression_controller #(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              load_x,
  output logic              load_y,
  output logic              load_sum_x,
  output logic              load_sum_y,
  output logic              init_sum_XR,
  output logic              init_sum_YR,
  output logic              load_min_x,
  output logic              load_min_y,
  output logic              load_ssXY,
  output logic              load_ssXX,
  output logic              init_RssXY,
  output logic              init_RssXX,
  output logic              load_b1,
  output logic              load_b0,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT  = 4'd1,
    S_LOAD1 = 4'd2,
    S_ACC1  = 4'd3,
    S_MEAN  = 4'd4,
    S_LOAD2 = 4'd5,
    S_ACC2  = 4'd6,
    S_B1    = 4'd7,
    S_B0    = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Memory handshake: in a LOAD state mem_rd is the request and mem_ready the valid;
  // a sample is consumed only in a cycle where both are high, otherwise the FSM and
  // mem_addr hold.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        addr_d  = '0;
        state_d = S_LOAD1;
      end
      S_LOAD1: begin
        if (mem_ready) state_d = S_ACC1;
      end
      S_ACC1: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_MEAN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD1;
        end
      end
      S_MEAN: begin
        state_d = S_LOAD2;
      end
      S_LOAD2: begin
        if (mem_ready) state_d = S_ACC2;
      end
      S_ACC2: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_B1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD2;
        end
      end
      // b0 is computed from the registered b1, so the intercept loads a cycle later.
      S_B1:    state_d = S_B0;
      S_B0:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    mem_rd      = 1'b0;
    load_x      = 1'b0;
    load_y      = 1'b0;
    load_sum_x  = 1'b0;
    load_sum_y  = 1'b0;
    init_sum_XR = 1'b0;
    init_sum_YR = 1'b0;
    load_min_x  = 1'b0;
    load_min_y  = 1'b0;
    load_ssXY   = 1'b0;
    load_ssXX   = 1'b0;
    init_RssXY  = 1'b0;
    init_RssXX  = 1'b0;
    load_b1     = 1'b0;
    load_b0     = 1'b0;
    case (state_q)
      S_INIT: begin
        init_sum_XR = 1'b1;
        init_sum_YR = 1'b1;
        init_RssXY  = 1'b1;
        init_RssXX  = 1'b1;
      end
      S_LOAD1, S_LOAD2: begin
        mem_rd = 1'b1;
        load_x = mem_ready;
        load_y = mem_ready;
      end
      S_ACC1: begin
        load_sum_x = 1'b1;
        load_sum_y = 1'b1;
      end
      S_MEAN: begin
        load_min_x = 1'b1;
        load_min_y = 1'b1;
      end
      S_ACC2: begin
        load_ssXY = 1'b1;
        load_ssXX = 1'b1;
      end
      S_B1:    load_b1 = 1'b1;
      S_B0:    load_b0 = 1'b1;
      S_DONE:  done    = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_regression_controller.sv
// Bench for regression_controller: a run-position model predicts every output each cycle,
// and literal cycle counts for the scripted scenarios pin that model.
module tb_regression_controller;

  localparam int N       = 150;
  localparam int AW      = 8;
  localparam int W       = AW + 17;
  localparam int RUN_LEN = 4 * N + 5;

  logic clk = 1'b0;
  logic reset, start, mem_ready;
  logic busy, done, mem_rd;
  logic [AW-1:0] mem_addr;
  logic load_x, load_y, load_sum_x, load_sum_y, init_sum_XR, init_sum_YR;
  logic load_min_x, load_min_y, load_ssXY, load_ssXX, init_RssXY, init_RssXX;
  logic load_b1, load_b0;
  logic [3:0] state_dbg;
  logic [W-1:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  regression_controller #(.N_SAMPLES(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .load_x(load_x), .load_y(load_y), .load_sum_x(load_sum_x), .load_sum_y(load_sum_y),
    .init_sum_XR(init_sum_XR), .init_sum_YR(init_sum_YR),
    .load_min_x(load_min_x), .load_min_y(load_min_y),
    .load_ssXY(load_ssXY), .load_ssXX(load_ssXX),
    .init_RssXY(init_RssXY), .init_RssXX(init_RssXX),
    .load_b1(load_b1), .load_b0(load_b0), .state_dbg(state_dbg)
  );

  assign dut_vec = {busy, done, mem_rd, mem_addr, load_x, load_y, load_sum_x, load_sum_y,
                    init_sum_XR, init_sum_YR, load_min_x, load_min_y, load_ssXY, load_ssXX,
                    init_RssXY, init_RssXX, load_b1, load_b0};

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a run is a fixed schedule of positions 0..RUN_LEN-1:
  // 0 init, then N (load,acc) pairs, mean, N (load,acc) pairs, b1, b0, done.
  bit m_active;
  int m_p;

  function automatic bit is_load_pos(int p);
    return (p >= 1 && p <= 2*N && ((p - 1) % 2) == 0) ||
           (p >= 2*N + 2 && p <= 4*N + 1 && ((p - 2*N - 2) % 2) == 0);
  endfunction

  function automatic logic [W-1:0] exp_outs(bit act, int p, bit rdy);
    logic b, d, rd, lx, sx, in, mn, ss, b1, b0;
    logic [AW-1:0] a;
    b = act; d = 0; rd = 0; lx = 0; sx = 0; in = 0; mn = 0; ss = 0; b1 = 0; b0 = 0;
    a = '0;
    if (act) begin
      if (p == 0) in = 1;
      else if (p <= 2*N) begin
        a = AW'((p - 1) / 2);
        if (is_load_pos(p)) begin rd = 1; lx = rdy; end else sx = 1;
      end else if (p == 2*N + 1) mn = 1;
      else if (p <= 4*N + 1) begin
        a = AW'((p - 2*N - 2) / 2);
        if (is_load_pos(p)) begin rd = 1; lx = rdy; end else ss = 1;
      end else if (p == 4*N + 2) b1 = 1;
      else if (p == 4*N + 3) b0 = 1;
      else d = 1;
    end
    return {b, d, rd, a, lx, lx, sx, sx, in, in, mn, mn, ss, ss, in, in, b1, b0};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0;
      m_p      = 0;
    end else if (!m_active) begin
      if (start) begin m_active = 1; m_p = 0; end
    end else if (is_load_pos(m_p) && !mem_ready) begin
      m_p = m_p;
    end else if (m_p == RUN_LEN - 1) begin
      m_active = 0;
    end else begin
      m_p++;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (check_en) begin
      e = exp_outs(m_active, m_p, mem_ready);
      n_checks++;
      if (dut_vec !== e) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL outputs at t=%0t: got %h, expected %h", $time, dut_vec, e);
      end
    end
  end

  // Per-run pulse totals, checked when done fires.
  int c_sum, c_ss, c_x, c_min, c_b1, c_b0;
  always @(negedge clk) begin
    if (check_en && !reset) begin
      if (init_sum_XR) begin
        c_sum = 0; c_ss = 0; c_x = 0; c_min = 0; c_b1 = 0; c_b0 = 0;
      end
      c_sum += int'(load_sum_x);
      c_ss  += int'(load_ssXY);
      c_x   += int'(load_x);
      c_min += int'(load_min_x);
      c_b1  += int'(load_b1);
      c_b0  += int'(load_b0);
      if (done) begin
        chk("count_load_sum_x", c_sum, N);
        chk("count_load_ssXY", c_ss, N);
        chk("count_load_x", c_x, 2*N);
        chk("count_load_min_x", c_min, 1);
        chk("count_load_b1", c_b1, 1);
        chk("count_load_b0", c_b0, 1);
      end
    end
  end

  // Entered in the INIT cycle (cycle 1). done_cyc: cycle of done, -1 if reset, 0 on timeout.
  task automatic run_body(input int stall_at, input int stall_len, input int stall_addr,
                          input int extra_at, input int reset_at, input bit rnd,
                          input bit hold, output int done_cyc);
    int cyc;
    done_cyc = 0;
    cyc = 1;
    while (done_cyc == 0 && cyc <= 4000) begin
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
      else     mem_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (!hold) start = (cyc == extra_at);
      if (cyc == reset_at) begin
        reset = 1'b1;
        #1;
        chk("reset_async_outputs", dut_vec, 0);
        @(negedge clk);
        chk("reset_no_done", done, 0);
        step();
        reset = 1'b0;
        done_cyc = -1;
      end else begin
        @(negedge clk);
        if (cyc == 1)
          chk("init_pulse", {busy, init_sum_XR, init_sum_YR, init_RssXY, init_RssXX}, 5'b11111);
        if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
          chk("stall_load_x", load_x, 0);
          chk("stall_mem_rd", mem_rd, 1);
          chk("stall_mem_addr", mem_addr, stall_addr);
        end
        if (done) done_cyc = cyc;
        step();
        cyc++;
      end
    end
    if (done_cyc == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int d;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_state", dut_vec, 0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Plain run: INIT is cycle 1, done is cycle 4N+5.
    pulse_start();
    run_body(0, 0, 0, 0, 0, 0, 0, d);
    chk("latency_plain", d, 605);
    repeat (3) step();

    // Three-cycle stall on sample 10 of pass 2 (LOAD2 of sample 10 is cycle 323).
    pulse_start();
    run_body(323, 3, 10, 0, 0, 0, 0, d);
    chk("latency_stalled", d, 608);
    repeat (3) step();

    // Reset mid-run, then a clean restart.
    pulse_start();
    run_body(0, 0, 0, 0, 50, 0, 0, d);
    chk("reset_abort", d, -1);
    repeat (3) step();
    pulse_start();
    run_body(0, 0, 0, 0, 0, 0, 0, d);
    chk("latency_after_reset", d, 605);
    repeat (3) step();

    // start while busy is ignored.
    pulse_start();
    run_body(0, 0, 0, 100, 0, 0, 0, d);
    chk("latency_extra_start", d, 605);
    repeat (5) step();

    // start held: DONE -> IDLE for one cycle, then the next INIT.
    start = 1'b1;
    step();
    run_body(0, 0, 0, 0, 0, 0, 1, d);
    chk("latency_hold_1", d, 605);
    @(negedge clk);
    chk("hold_idle_gap_busy", busy, 0);
    step();
    start = 1'b0;
    run_body(0, 0, 0, 0, 0, 0, 0, d);
    chk("latency_hold_2", d, 605);
    repeat (3) step();

    // Randomized memory readiness, stray starts and an occasional reset.
    for (int i = 0; i < 6; i++) begin
      pulse_start();
      run_body(0, 0, 0, int'($urandom_range(0, 700)), (i == 3) ? int'($urandom_range(2, 500)) : 0,
               1, 0, d);
      repeat ($urandom_range(1, 4)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
